// File: rtl/data_in_tag_gen.sv
// data_in_tag_gen: front end of the input-data FIFO on clk_data.
// It counts words, groups and slices of the raw feature stream and writes
// {20-bit tag, data} entries to the FIFO. After every slice it writes one
// slice-marker entry. The source is stalled while the FIFO reports full.
module data_in_tag_gen #(
  parameter int BANDWIDTH = 512,
  parameter int BITWIDTH  = 32
) (
  input  logic                   clk_data,
  input  logic                   rst,
  input  logic                   cfg_vld,
  output logic                   cfg_rdy,
  input  logic [6:0]             cfg_layer_type,
  input  logic [6:0]             cfg_acc_para,
  input  logic                   cfg_relu_en,
  input  logic                   cfg_pw_sc_en,
  input  logic [9:0]             cfg_words_per_grp,
  input  logic [9:0]             cfg_grps_per_slc,
  input  logic [7:0]             cfg_slcs_per_lyr,
  input  logic [BANDWIDTH-1:0]   data_in,
  input  logic                   data_in_vld,
  output logic                   data_in_rdy,
  input  logic                   fifo_vector_full,
  output logic                   fifo_wr_en,
  output logic [BANDWIDTH+19:0]  fifo_wr_all,
  output logic                   layer_done
);

  // The unpack order on the calc side assumes 16 lanes per word.
  if (BANDWIDTH != BITWIDTH * 16) begin : g_bad_width
    $error("data_in_tag_gen: BANDWIDTH must equal 16*BITWIDTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_MARK = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t         state_r;
  state_t         state_nx_s;

  // Latched descriptor (zero sizes already clamped to 1)
  logic [6:0]     type_r;
  logic [6:0]     acc_r;
  logic           relu_r;
  logic           pw_r;
  logic [9:0]     wpg_r;
  logic [9:0]     gps_r;
  logic [7:0]     sps_r;

  logic [9:0]     word_cnt_r;
  logic [9:0]     grp_cnt_r;
  logic [7:0]     slc_cnt_r;

  logic           accept_s;
  logic           mark_wr_s;
  logic           last_word_s;
  logic           last_grp_s;
  logic           last_slc_s;
  logic           cfg_take_s;
  logic [19:0]    data_tag_s;
  logic [19:0]    mark_tag_s;

  assign cfg_rdy     = (state_r == ST_IDLE);
  assign data_in_rdy = (state_r == ST_RUN) & ~fifo_vector_full;

  // Position decode, handshakes and the two tag flavours
  always_comb begin
    last_word_s = (word_cnt_r == (wpg_r - 10'd1));
    last_grp_s  = (grp_cnt_r == (gps_r - 10'd1));
    last_slc_s  = (slc_cnt_r == (sps_r - 8'd1));
    cfg_take_s  = (state_r == ST_IDLE) & cfg_vld;
    accept_s    = (state_r == ST_RUN) & ~fifo_vector_full & data_in_vld;
    mark_wr_s   = (state_r == ST_MARK) & ~fifo_vector_full;
    data_tag_s  = {type_r, 1'b1, (word_cnt_r == 10'd0), relu_r & last_word_s,
                   last_word_s & last_grp_s & last_slc_s, acc_r, 1'b0,
                   pw_r & last_word_s};
    mark_tag_s  = {type_r, 1'b0, 1'b0, 1'b0, 1'b0, acc_r, 1'b1, 1'b0};
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cfg_vld) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s && last_word_s && last_grp_s) begin
          state_nx_s = ST_MARK;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_MARK: begin
        if (!fifo_vector_full) begin
          if (last_slc_s) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_RUN;
          end
        end else begin
          state_nx_s = ST_MARK;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_data) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Descriptor capture; zero sizes behave as one
  always_ff @(posedge clk_data) begin
    if (rst) begin
      type_r <= 7'd0;
      acc_r  <= 7'd0;
      relu_r <= 1'b0;
      pw_r   <= 1'b0;
      wpg_r  <= 10'd0;
      gps_r  <= 10'd0;
      sps_r  <= 8'd0;
    end else if (cfg_take_s) begin
      type_r <= cfg_layer_type;
      acc_r  <= cfg_acc_para;
      relu_r <= cfg_relu_en;
      pw_r   <= cfg_pw_sc_en;
      wpg_r  <= (cfg_words_per_grp == 10'd0) ? 10'd1 : cfg_words_per_grp;
      gps_r  <= (cfg_grps_per_slc == 10'd0) ? 10'd1 : cfg_grps_per_slc;
      sps_r  <= (cfg_slcs_per_lyr == 8'd0) ? 8'd1 : cfg_slcs_per_lyr;
    end
  end

  // Word/group counters advance on accepted words, slice counter on markers
  always_ff @(posedge clk_data) begin
    if (rst || cfg_take_s) begin
      word_cnt_r <= 10'd0;
      grp_cnt_r  <= 10'd0;
      slc_cnt_r  <= 8'd0;
    end else begin
      if (accept_s) begin
        if (last_word_s) begin
          word_cnt_r <= 10'd0;
          if (last_grp_s) begin
            grp_cnt_r <= 10'd0;
          end else begin
            grp_cnt_r <= grp_cnt_r + 10'd1;
          end
        end else begin
          word_cnt_r <= word_cnt_r + 10'd1;
        end
      end
      if (mark_wr_s) begin
        if (last_slc_s) begin
          slc_cnt_r <= 8'd0;
        end else begin
          slc_cnt_r <= slc_cnt_r + 8'd1;
        end
      end
    end
  end

  // Registered FIFO write port and end-of-layer pulse
  always_ff @(posedge clk_data) begin
    if (rst) begin
      fifo_wr_en  <= 1'b0;
      fifo_wr_all <= '0;
      layer_done  <= 1'b0;
    end else begin
      fifo_wr_en <= accept_s | mark_wr_s;
      layer_done <= (state_r == ST_DONE);
      if (accept_s) begin
        fifo_wr_all <= {data_tag_s, data_in};
      end else if (mark_wr_s) begin
        fifo_wr_all <= {mark_tag_s, {BANDWIDTH{1'b0}}};
      end
    end
  end

endmodule

// File: tb/tb_data_in_tag_gen.sv
// Scoreboard bench for data_in_tag_gen: the driver pushes the expected FIFO
// entries as words transfer; a monitor pops and compares every FIFO write.
module tb_data_in_tag_gen;

  localparam int BW = 512;
  localparam int EW = BW + 20;

  logic           clk_data = 1'b0;
  logic           rst;
  logic           cfg_vld;
  logic           cfg_rdy;
  logic [6:0]     cfg_layer_type;
  logic [6:0]     cfg_acc_para;
  logic           cfg_relu_en;
  logic           cfg_pw_sc_en;
  logic [9:0]     cfg_words_per_grp;
  logic [9:0]     cfg_grps_per_slc;
  logic [7:0]     cfg_slcs_per_lyr;
  logic [BW-1:0]  data_in;
  logic           data_in_vld;
  logic           data_in_rdy;
  logic           fifo_vector_full;
  logic           fifo_wr_en;
  logic [EW-1:0]  fifo_wr_all;
  logic           layer_done;

  always #5 clk_data = ~clk_data;

  data_in_tag_gen #(.BANDWIDTH(BW), .BITWIDTH(32)) dut (
    .clk_data(clk_data), .rst(rst), .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy),
    .cfg_layer_type(cfg_layer_type), .cfg_acc_para(cfg_acc_para),
    .cfg_relu_en(cfg_relu_en), .cfg_pw_sc_en(cfg_pw_sc_en),
    .cfg_words_per_grp(cfg_words_per_grp), .cfg_grps_per_slc(cfg_grps_per_slc),
    .cfg_slcs_per_lyr(cfg_slcs_per_lyr), .data_in(data_in),
    .data_in_vld(data_in_vld), .data_in_rdy(data_in_rdy),
    .fifo_vector_full(fifo_vector_full), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_all(fifo_wr_all), .layer_done(layer_done)
  );

  typedef struct packed {
    logic          last;
    logic [EW-1:0] ent;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   markers_seen = 0;
  bit   done_pending = 1'b0;
  bit   done_seen = 1'b0;

  function automatic logic [EW-1:0] mk(input logic [6:0] typ, input logic calc,
      input logic acc_s, input logic relu, input logic lf, input logic [6:0] acc,
      input logic sf, input logic pw, input logic [BW-1:0] d);
    return {typ, calc, acc_s, relu, lf, acc, sf, pw, d};
  endfunction

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] rand_word();
    logic [BW-1:0] w;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  // Monitor: every FIFO write must match the head of the expected queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_data);
      if (rst) begin
        done_pending = 1'b0;
      end else begin
        chk("layer_done", EW'(layer_done), EW'(done_pending));
        if (layer_done) done_seen = 1'b1;
        done_pending = 1'b0;
        if (fifo_wr_en) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=%h required=no_write", fifo_wr_all);
          end else begin
            e = q.pop_front();
            chk("fifo_entry", fifo_wr_all, e.ent);
            if (fifo_wr_all[BW+1]) markers_seen++;
            if (e.last) done_pending = 1'b1;
          end
        end
      end
    end
  end

  // One layer: descriptor handshake, word stream with optional stalls/abort
  task automatic run_layer(input logic [6:0] typ, input logic [6:0] acc, input bit relu,
      input bit pw, input int w_cfg, input int g_cfg, input int s_cfg, input bit rand_full,
      input int hold_at, input bit mark_hold, input int abort_at, input bit glitch);
    int W, G, S, total, k, hold_left, mhold_left, guard, wi;
    bit xfer, hold_used, glitch_done, aborted, lg;
    logic [BW-1:0] cur;
    exp_t e;
    W = (w_cfg == 0) ? 1 : w_cfg;
    G = (g_cfg == 0) ? 1 : g_cfg;
    S = (s_cfg == 0) ? 1 : s_cfg;
    total = W * G * S;
    k = 0; hold_left = 0; mhold_left = 0; guard = 0;
    hold_used = 1'b0; glitch_done = 1'b0; aborted = 1'b0;

    cfg_vld = 1'b1;
    cfg_layer_type = typ; cfg_acc_para = acc; cfg_relu_en = relu; cfg_pw_sc_en = pw;
    cfg_words_per_grp = 10'(w_cfg); cfg_grps_per_slc = 10'(g_cfg); cfg_slcs_per_lyr = 8'(s_cfg);
    data_in_vld = 1'b1; data_in = rand_word(); fifo_vector_full = 1'b0;
    @(negedge clk_data);
    chk("cfg_rdy_idle", EW'(cfg_rdy), EW'(1'b1));
    chk("no_accept_idle", EW'(data_in_rdy), EW'(1'b0));
    @(posedge clk_data); #1;
    cfg_vld = 1'b0;
    cfg_layer_type = 7'($urandom()); cfg_acc_para = 7'($urandom());
    cfg_relu_en = 1'($urandom()); cfg_pw_sc_en = 1'($urandom());
    cfg_words_per_grp = 10'($urandom()); cfg_grps_per_slc = 10'($urandom());
    cfg_slcs_per_lyr = 8'($urandom());
    markers_seen = 0; done_seen = 1'b0;
    cur = rand_word();

    while (!done_seen && guard < 3000) begin
      guard++;
      if (k < total) data_in_vld = ($urandom_range(0, 3) != 0);
      else data_in_vld = 1'b1;
      fifo_vector_full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (hold_at >= 0 && k == hold_at && !hold_used) begin
        hold_left = 5;
        hold_used = 1'b1;
      end
      if (hold_left > 0) begin
        fifo_vector_full = 1'b1;
        data_in_vld = 1'b1;
        hold_left--;
      end
      if (mhold_left > 0) begin
        fifo_vector_full = 1'b1;
        mhold_left--;
      end
      if (glitch && !glitch_done && k == total / 2) begin
        cfg_vld = 1'b1;
        cfg_layer_type = typ + 7'd1;
        glitch_done = 1'b1;
      end else begin
        cfg_vld = 1'b0;
      end
      data_in = cur;
      @(negedge clk_data);
      xfer = data_in_vld & data_in_rdy;
      if (fifo_vector_full) chk("rdy_while_full", EW'(data_in_rdy), EW'(1'b0));
      if (k >= total) chk("no_accept_after_last", EW'(data_in_rdy), EW'(1'b0));
      @(posedge clk_data); #1;
      if (xfer && k < total) begin
        wi = k % W;
        lg = (wi == W - 1);
        e.last = 1'b0;
        e.ent = mk(typ, 1'b1, (wi == 0), relu & lg, (k == total - 1), acc, 1'b0, pw & lg, cur);
        q.push_back(e);
        if (((k + 1) % (W * G)) == 0) begin
          e.last = (k == total - 1);
          e.ent = mk(typ, 1'b0, 1'b0, 1'b0, 1'b0, acc, 1'b1, 1'b0, {BW{1'b0}});
          q.push_back(e);
          if (mark_hold) mhold_left = 4;
        end
        k++;
        cur = rand_word();
      end
      if (abort_at > 0 && k == abort_at) begin
        aborted = 1'b1;
        break;
      end
    end

    data_in_vld = 1'b0;
    fifo_vector_full = 1'b0;
    cfg_vld = 1'b0;
    if (aborted) begin
      rst = 1'b1;
      @(posedge clk_data); #1;
      @(negedge clk_data);
      chk("abort_wr_en", EW'(fifo_wr_en), EW'(1'b0));
      chk("abort_wr_all", fifo_wr_all, {EW{1'b0}});
      chk("abort_cfg_rdy", EW'(cfg_rdy), EW'(1'b1));
      chk("abort_data_rdy", EW'(data_in_rdy), EW'(1'b0));
      chk("abort_layer_done", EW'(layer_done), EW'(1'b0));
      @(posedge clk_data); #1;
      rst = 1'b0;
      q.delete();
    end else begin
      chk("layer_done_seen", EW'(done_seen), EW'(1'b1));
      chk("queue_drained", EW'(q.size()), EW'(0));
      chk("marker_count", EW'(markers_seen), EW'(S));
      chk("cfg_rdy_after", EW'(cfg_rdy), EW'(1'b1));
    end
  endtask

  // Stimulus sequence
  initial begin
    rst = 1'b1; cfg_vld = 1'b0; cfg_layer_type = 7'd0; cfg_acc_para = 7'd0;
    cfg_relu_en = 1'b0; cfg_pw_sc_en = 1'b0; cfg_words_per_grp = 10'd0;
    cfg_grps_per_slc = 10'd0; cfg_slcs_per_lyr = 8'd0; data_in = '0;
    data_in_vld = 1'b0; fifo_vector_full = 1'b0;
    repeat (3) @(posedge clk_data);
    #1;
    @(negedge clk_data);
    chk("rst_wr_en", EW'(fifo_wr_en), EW'(1'b0));
    chk("rst_wr_all", fifo_wr_all, {EW{1'b0}});
    chk("rst_layer_done", EW'(layer_done), EW'(1'b0));
    chk("rst_data_rdy", EW'(data_in_rdy), EW'(1'b0));
    chk("rst_cfg_rdy", EW'(cfg_rdy), EW'(1'b1));
    @(posedge clk_data); #1;
    rst = 1'b0;
    @(posedge clk_data); #1;

    // typ acc relu pw W G S rand_full hold_at mark_hold abort_at glitch
    run_layer(7'd0, 7'd5,  1'b1, 1'b0, 2, 2, 1, 1'b0, -1, 1'b0, 0, 1'b0);
    run_layer(7'd2, 7'd9,  1'b0, 1'b0, 1, 1, 3, 1'b0, -1, 1'b0, 0, 1'b0);
    run_layer(7'd1, 7'd17, 1'b1, 1'b1, 3, 2, 2, 1'b0,  4, 1'b0, 0, 1'b0);
    run_layer(7'd4, 7'd33, 1'b0, 1'b1, 2, 2, 2, 1'b0, -1, 1'b1, 0, 1'b0);
    run_layer(7'd3, 7'd2,  1'b1, 1'b0, 2, 3, 3, 1'b0, -1, 1'b0, 8, 1'b0);
    run_layer(7'd0, 7'd70, 1'b1, 1'b1, 0, 2, 2, 1'b0, -1, 1'b0, 0, 1'b0);
    run_layer(7'd1, 7'd44, 1'b0, 1'b1, 2, 2, 2, 1'b0, -1, 1'b0, 0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      run_layer(7'($urandom_range(0, 4)), 7'($urandom()), 1'($urandom()), 1'($urandom()),
                $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
                1'b1, -1, 1'b0, 0, 1'($urandom()));
    end

    repeat (3) @(posedge clk_data);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
